// File: rtl/cpu_ctrl_pkg.sv
// Shared types, opcode/ALU encodings and decode helpers for the hardwired CPU controller.
package cpu_ctrl_pkg;

  localparam int OP_W  = 5;
  localparam int SEL_W = 4;

  // Controller phases: fetch (T0..T2), execute (T3..T6), plus reset and halt parking states.
  typedef enum logic [3:0] {
    RESET_ST,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    T6,
    HALT_ST
  } state_t;

  // Execution class selects which T3..T6 sequence an instruction follows.
  typedef enum logic [2:0] {
    CL_ALU,
    CL_UNARY,
    CL_MULDIV,
    CL_NOP,
    CL_HALT,
    CL_ILLEGAL
  } instr_class_t;

  // Decoded instruction fields, latched by the sequencer for the execute phase.
  typedef struct packed {
    instr_class_t     cls;
    logic [OP_W-1:0]  alu_op;
    logic [SEL_W-1:0] ra;
    logic [SEL_W-1:0] rb;
    logic [SEL_W-1:0] rc;
  } decoded_t;

  // Instruction opcodes (IR[31:27]); encodings not listed here are illegal for this controller.
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b01000;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01001;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01010;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  // ALU operation codes driven on the operation port.
  localparam logic [OP_W-1:0] ALU_NOP  = 5'b00000;
  localparam logic [OP_W-1:0] ALU_ADD  = 5'b00001;
  localparam logic [OP_W-1:0] ALU_SUB  = 5'b00010;
  localparam logic [OP_W-1:0] ALU_AND  = 5'b00011;
  localparam logic [OP_W-1:0] ALU_OR   = 5'b00100;
  localparam logic [OP_W-1:0] ALU_MUL  = 5'b00101;
  localparam logic [OP_W-1:0] ALU_DIV  = 5'b00110;
  localparam logic [OP_W-1:0] ALU_NEG  = 5'b00111;
  localparam logic [OP_W-1:0] ALU_NOT  = 5'b01000;
  localparam logic [OP_W-1:0] ALU_SHR  = 5'b01001;
  localparam logic [OP_W-1:0] ALU_SHRA = 5'b01010;
  localparam logic [OP_W-1:0] ALU_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] ALU_ROR  = 5'b01100;
  localparam logic [OP_W-1:0] ALU_ROL  = 5'b01101;

  // Map an instruction opcode to the ALU operation it requests.
  function automatic logic [OP_W-1:0] alu_op_of(input logic [OP_W-1:0] opcode);
    logic [OP_W-1:0] op;
    case (opcode)
      OP_ADD:  op = ALU_ADD;
      OP_SUB:  op = ALU_SUB;
      OP_AND:  op = ALU_AND;
      OP_OR:   op = ALU_OR;
      OP_SHR:  op = ALU_SHR;
      OP_SHRA: op = ALU_SHRA;
      OP_SHL:  op = ALU_SHL;
      OP_ROR:  op = ALU_ROR;
      OP_ROL:  op = ALU_ROL;
      OP_MUL:  op = ALU_MUL;
      OP_DIV:  op = ALU_DIV;
      OP_NEG:  op = ALU_NEG;
      OP_NOT:  op = ALU_NOT;
      default: op = ALU_NOP;
    endcase
    return op;
  endfunction

  // Map an instruction opcode to its execution class.
  function automatic instr_class_t class_of(input logic [OP_W-1:0] opcode);
    instr_class_t cls;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: cls = CL_ALU;
      OP_NEG, OP_NOT:                          cls = CL_UNARY;
      OP_MUL, OP_DIV:                          cls = CL_MULDIV;
      OP_NOP:                                  cls = CL_NOP;
      OP_HALT:                                 cls = CL_HALT;
      default:                                 cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_sequencer_instr_decoder.sv
// Combinational instruction decoder: class, ALU op and register fields from the IR word.
module instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output decoded_t    dec
);

  logic [OP_W-1:0]  opcode;
  logic [SEL_W-1:0] fields [3];
  logic             unused_low;

  assign opcode     = ir[31:27];
  // Immediate/constant bits are not used by any instruction this controller executes.
  assign unused_low = ^ir[14:0];

  // Ra, Rb, Rc occupy consecutive 4-bit fields directly below the opcode.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_field
      assign fields[gi] = ir[26-4*gi -: SEL_W];
    end
  endgenerate

  // Assemble the decoded record.
  always_comb begin
    dec.cls    = class_of(opcode);
    dec.alu_op = alu_op_of(opcode);
    dec.ra     = fields[0];
    dec.rb     = fields[1];
    dec.rc     = fields[2];
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore controller for the bus-based CPU datapath: fetch, decode and execute sequencing.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW     = 5,
  parameter int REGSELW = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [31:0]        IR,
  input  logic               mem_ready,
  output logic               PCout,
  output logic               ZLowout,
  output logic               ZHighout,
  output logic               MDRout,
  output logic               MARin,
  output logic               PCin,
  output logic               MDRin,
  output logic               IRin,
  output logic               Yin,
  output logic               Zin,
  output logic               HIin,
  output logic               LOin,
  output logic               IncPC,
  output logic               Read,
  output logic               reg_out_en,
  output logic [REGSELW-1:0] reg_out_sel,
  output logic               reg_in_en,
  output logic [REGSELW-1:0] reg_in_sel,
  output logic [OPW-1:0]     operation,
  output logic               run,
  output logic               illegal_op
);

  state_t   state_reg;
  state_t   state_next;
  decoded_t dec_now;
  decoded_t dec_reg;

  instr_decoder u_decoder (
    .ir  (IR),
    .dec (dec_now)
  );

  // State register; Reset forces RESET_ST from any state, even mid-instruction.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= RESET_ST;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the decoded IR while in T2 so execute outputs ignore later IR changes.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      dec_reg <= '0;
    end else if (state_reg == T2) begin
      dec_reg <= dec_now;
    end
  end

  // Next-state logic: fixed fetch, class-dependent execute length.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RESET_ST: state_next = T0;
      T0:       state_next = T1;
      T1:       state_next = mem_ready ? T2 : T1;
      T2:       state_next = T3;
      T3: begin
        case (dec_reg.cls)
          CL_ALU, CL_UNARY, CL_MULDIV: state_next = T4;
          CL_HALT:                     state_next = HALT_ST;
          default:                     state_next = T0;
        endcase
      end
      T4:       state_next = (dec_reg.cls == CL_UNARY) ? T0 : T5;
      T5:       state_next = (dec_reg.cls == CL_MULDIV) ? T6 : T0;
      T6:       state_next = T0;
      HALT_ST:  state_next = HALT_ST;
      default:  state_next = RESET_ST;
    endcase
  end

  // Moore output decode from the state register and the latched fields.
  always_comb begin
    PCout       = 1'b0;
    ZLowout     = 1'b0;
    ZHighout    = 1'b0;
    MDRout      = 1'b0;
    MARin       = 1'b0;
    PCin        = 1'b0;
    MDRin       = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    IncPC       = 1'b0;
    Read        = 1'b0;
    reg_out_en  = 1'b0;
    reg_out_sel = '0;
    reg_in_en   = 1'b0;
    reg_in_sel  = '0;
    operation   = '0;
    illegal_op  = 1'b0;
    run         = (state_reg != RESET_ST) && (state_reg != HALT_ST);
    case (state_reg)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        ZLowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        case (dec_reg.cls)
          CL_ALU: begin
            reg_out_en  = 1'b1;
            reg_out_sel = REGSELW'(dec_reg.rb);
            Yin         = 1'b1;
          end
          CL_UNARY: begin
            reg_out_en  = 1'b1;
            reg_out_sel = REGSELW'(dec_reg.rb);
            operation   = OPW'(dec_reg.alu_op);
            Zin         = 1'b1;
          end
          CL_MULDIV: begin
            reg_out_en  = 1'b1;
            reg_out_sel = REGSELW'(dec_reg.ra);
            Yin         = 1'b1;
          end
          CL_ILLEGAL: illegal_op = 1'b1;
          default: ;
        endcase
      end
      T4: begin
        case (dec_reg.cls)
          CL_ALU: begin
            reg_out_en  = 1'b1;
            reg_out_sel = REGSELW'(dec_reg.rc);
            operation   = OPW'(dec_reg.alu_op);
            Zin         = 1'b1;
          end
          CL_UNARY: begin
            ZLowout    = 1'b1;
            reg_in_en  = 1'b1;
            reg_in_sel = REGSELW'(dec_reg.ra);
          end
          CL_MULDIV: begin
            reg_out_en  = 1'b1;
            reg_out_sel = REGSELW'(dec_reg.rb);
            operation   = OPW'(dec_reg.alu_op);
            Zin         = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (dec_reg.cls)
          CL_ALU: begin
            ZLowout    = 1'b1;
            reg_in_en  = 1'b1;
            reg_in_sel = REGSELW'(dec_reg.ra);
          end
          CL_MULDIV: begin
            ZLowout = 1'b1;
            LOin    = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        ZHighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle strobe checks for each instruction class.
module tb_control_sequencer;

  logic        Clock;
  logic        Reset;
  logic [31:0] IR;
  logic        mem_ready;
  logic        PCout, ZLowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin;
  logic        Yin, Zin, HIin, LOin, IncPC, Read;
  logic        reg_out_en, reg_in_en, run, illegal_op;
  logic [3:0]  reg_out_sel, reg_in_sel;
  logic [4:0]  operation;

  int n_cmp = 0;
  int n_mis = 0;

  // Strobe bit masks in the packing order used by obs().
  localparam logic [17:0] PCO = 18'h20000, ZLO = 18'h10000, ZHO = 18'h08000, MDO = 18'h04000;
  localparam logic [17:0] MARI = 18'h02000, PCI = 18'h01000, MDRI = 18'h00800, IRI = 18'h00400;
  localparam logic [17:0] YI = 18'h00200, ZI = 18'h00100, HII = 18'h00080, LOI = 18'h00040;
  localparam logic [17:0] INC = 18'h00020, RD = 18'h00010, ROE = 18'h00008, RIE = 18'h00004;
  localparam logic [17:0] ILL = 18'h00002, RUN = 18'h00001;
  localparam logic [17:0] T0S = PCO | MARI | INC | ZI | RUN;
  localparam logic [17:0] T1S = ZLO | PCI | RD | MDRI | RUN;
  localparam logic [17:0] T2S = MDO | IRI | RUN;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .mem_ready(mem_ready),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .reg_out_en(reg_out_en), .reg_out_sel(reg_out_sel),
    .reg_in_en(reg_in_en), .reg_in_sel(reg_in_sel),
    .operation(operation), .run(run), .illegal_op(illegal_op)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic logic [30:0] obs();
    return {PCout, ZLowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin,
            HIin, LOin, IncPC, Read, reg_out_en, reg_in_en, illegal_op, run,
            reg_out_sel, reg_in_sel, operation};
  endfunction

  function automatic logic [30:0] ev(input logic [17:0] s, input logic [3:0] os,
                                     input logic [3:0] is, input logic [4:0] op);
    return {s, os, is, op};
  endfunction

  // Every cycle: single bus driver and zeroed selects when the matching enable is low.
  always @(negedge Clock) begin
    n_cmp++;
    if ($countones({PCout, ZLowout, ZHighout, MDRout, reg_out_en}) > 1) begin
      n_mis++;
      $display("FAIL bus_exclusive t=%0t drivers=%b required at most one", $time,
               {PCout, ZLowout, ZHighout, MDRout, reg_out_en});
    end
    n_cmp++;
    if ((!reg_out_en && reg_out_sel !== 4'd0) || (!reg_in_en && reg_in_sel !== 4'd0)) begin
      n_mis++;
      $display("FAIL sel_zero t=%0t out_sel=%0d in_sel=%0d required 0 when disabled", $time,
               reg_out_sel, reg_in_sel);
    end
  end

  task automatic test_reset();
    logic [30:0] e;
    Reset = 1'b1; mem_ready = 1'b1; IR = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      e = ev(18'h0, 4'd0, 4'd0, 5'd0); n_cmp++;
      if (obs() !== e) begin n_mis++; $display("FAIL reset_outputs_%0d got %h want %h", i, obs(), e); end
    end
    Reset = 1'b0;
    @(negedge Clock);
    e = ev(T0S, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL reset_release_T0 got %h want %h", obs(), e); end
  endtask

  task automatic test_alu_shr();
    logic [30:0] e;
    IR = 32'h2A2B8000; mem_ready = 1'b1;
    @(negedge Clock);
    e = ev(T1S, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL shr_T1 got %h want %h", obs(), e); end
    @(negedge Clock);
    e = ev(T2S, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL shr_T2 got %h want %h", obs(), e); end
    @(negedge Clock);
    e = ev(ROE | YI | RUN, 4'd5, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL shr_T3 got %h want %h", obs(), e); end
    @(negedge Clock);
    e = ev(ROE | ZI | RUN, 4'd7, 4'd0, 5'b01001); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL shr_T4 got %h want %h", obs(), e); end
    IR = 32'hFFFFFFFF;  // must not disturb the latched Ra
    @(negedge Clock);
    e = ev(ZLO | RIE | RUN, 4'd0, 4'd4, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL shr_T5 got %h want %h", obs(), e); end
    @(negedge Clock);
    e = ev(T0S, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL shr_back_T0 got %h want %h", obs(), e); end
  endtask

  task automatic test_mem_wait();
    logic [30:0] e;
    IR = 32'hD0000000; mem_ready = 1'b0;  // NOP
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      e = ev(T1S, 4'd0, 4'd0, 5'd0); n_cmp++;
      if (obs() !== e) begin n_mis++; $display("FAIL wait_T1_cycle%0d got %h want %h", i, obs(), e); end
      if (i == 3) mem_ready = 1'b1;
    end
    @(negedge Clock);
    e = ev(T2S, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL wait_T2 got %h want %h", obs(), e); end
    @(negedge Clock);
    e = ev(RUN, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL nop_T3 got %h want %h", obs(), e); end
    @(negedge Clock);
    e = ev(T0S, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL nop_back_T0 got %h want %h", obs(), e); end
  endtask

  task automatic test_unary();
    logic [30:0] e;
    IR = 32'h8B480000;  // NEG R6,R9
    repeat (3) @(negedge Clock);
    e = ev(ROE | ZI | RUN, 4'd9, 4'd0, 5'b00111); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL neg_T3 got %h want %h", obs(), e); end
    @(negedge Clock);
    e = ev(ZLO | RIE | RUN, 4'd0, 4'd6, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL neg_T4 got %h want %h", obs(), e); end
    @(negedge Clock);
    e = ev(T0S, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL neg_back_T0 got %h want %h", obs(), e); end
  endtask

  task automatic test_muldiv();
    logic [30:0] e;
    IR = 32'h79180000;  // MUL R2,R3
    repeat (3) @(negedge Clock);
    e = ev(ROE | YI | RUN, 4'd2, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL mul_T3 got %h want %h", obs(), e); end
    @(negedge Clock);
    e = ev(ROE | ZI | RUN, 4'd3, 4'd0, 5'b00101); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL mul_T4 got %h want %h", obs(), e); end
    @(negedge Clock);
    e = ev(ZLO | LOI | RUN, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL mul_T5 got %h want %h", obs(), e); end
    @(negedge Clock);
    e = ev(ZHO | HII | RUN, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL mul_T6 got %h want %h", obs(), e); end
    @(negedge Clock);
    e = ev(T0S, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL mul_back_T0 got %h want %h", obs(), e); end
  endtask

  task automatic test_reset_mid();
    logic [30:0] e;
    IR = 32'h18918000;  // ADD R1,R2,R3
    repeat (4) @(negedge Clock);
    e = ev(ROE | ZI | RUN, 4'd3, 4'd0, 5'b00001); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL add_T4 got %h want %h", obs(), e); end
    Reset = 1'b1;
    @(negedge Clock);
    e = ev(18'h0, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL midreset_outputs got %h want %h", obs(), e); end
    Reset = 1'b0;
    @(negedge Clock);
    e = ev(T0S, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL midreset_fetch got %h want %h", obs(), e); end
  endtask

  task automatic test_illegal_halt();
    logic [30:0] e;
    IR = 32'hF8000000;  // opcode 11111
    repeat (3) @(negedge Clock);
    e = ev(ILL | RUN, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL illegal_T3 got %h want %h", obs(), e); end
    IR = 32'hD8000000;  // HALT
    @(negedge Clock);
    e = ev(T0S, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL illegal_next_T0 got %h want %h", obs(), e); end
    repeat (3) @(negedge Clock);
    e = ev(RUN, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL halt_T3 got %h want %h", obs(), e); end
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      e = ev(18'h0, 4'd0, 4'd0, 5'd0); n_cmp++;
      if (obs() !== e) begin n_mis++; $display("FAIL halt_idle_%0d got %h want %h", i, obs(), e); end
    end
    Reset = 1'b1;
    @(negedge Clock);
    e = ev(18'h0, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL halt_reset got %h want %h", obs(), e); end
    Reset = 1'b0;
    @(negedge Clock);
    e = ev(T0S, 4'd0, 4'd0, 5'd0); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL halt_recover_T0 got %h want %h", obs(), e); end
  endtask

  initial begin
    test_reset();
    test_alu_shr();
    test_mem_wait();
    test_unary();
    test_muldiv();
    test_reset_mid();
    test_illegal_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
